// File: rtl/xor_parity_pkg.sv
// Shared definitions for xor_parity_acc: FSM state encoding and counter sizing.
// The optional expected-parity check is enabled with XOR_PARITY_ERRCHK_EN.
package xor_parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to hold a word count from 0 up to and including frame_len.
  function automatic int cnt_width(input int frame_len);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < (frame_len + 32'sd1)) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/xor_reduce.sv
// XOR-reduction of a W-bit vector; yields the even-parity bit of the vector.
module xor_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] vec,
  output logic         par
);

  assign par = ^vec;

endmodule

// File: rtl/xor_parity_acc.sv
// Folds FRAME_LEN words into one XOR word plus parity and hands it off over valid/ready.
// Define XOR_PARITY_ERRCHK_EN to add the in_exp / out_err expected-parity check.
module xor_parity_acc
  import xor_parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_word,
  output logic              out_parity
`ifdef XOR_PARITY_ERRCHK_EN
  ,
  input  logic              in_exp,
  output logic              out_err
`endif
);

  localparam int              CNT_W    = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_r;
  logic [DATA_W-1:0]   acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_word_r;
  logic                out_parity_r;

  logic                take_s;
  logic                last_s;
  logic                drain_s;
  logic [DATA_W-1:0]   next_acc_s;
  logic                next_par_s;

  assign take_s     = in_valid & in_ready_r;
  assign last_s     = take_s & (cnt_r == LAST_CNT);
  assign drain_s    = out_valid_r & out_ready;
  assign next_acc_s = acc_r ^ in_data;

  // Parity of the word about to be latched, so out_parity is registered with out_word.
  xor_reduce #(
    .W (DATA_W)
  ) u_xor_reduce (
    .vec (next_acc_s),
    .par (next_par_s)
  );

  // Frame FSM with accumulator, word counter and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      acc_r        <= '0;
      cnt_r        <= '0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_word_r   <= '0;
      out_parity_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (last_s) begin
            state_r      <= DONE;
            acc_r        <= next_acc_s;
            cnt_r        <= cnt_r + CNT_ONE;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b1;
            out_word_r   <= next_acc_s;
            out_parity_r <= next_par_s;
          end else if (take_s) begin
            state_r <= ACCUM;
            acc_r   <= next_acc_s;
            cnt_r   <= cnt_r + CNT_ONE;
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          // in_ready stays low through the handoff cycle, giving the inter-frame bubble.
          if (drain_s) begin
            state_r      <= IDLE;
            acc_r        <= '0;
            cnt_r        <= '0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_word_r   <= '0;
            out_parity_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r      <= IDLE;
          acc_r        <= '0;
          cnt_r        <= '0;
          in_ready_r   <= 1'b1;
          out_valid_r  <= 1'b0;
          out_word_r   <= '0;
          out_parity_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef XOR_PARITY_ERRCHK_EN
  logic out_err_r;

  // Compare the final parity with in_exp sampled alongside the last word of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err_r <= 1'b0;
    end else if (state_r != DONE && last_s) begin
      out_err_r <= next_par_s ^ in_exp;
    end else if (state_r == DONE && drain_s) begin
      out_err_r <= 1'b0;
    end else begin
      out_err_r <= out_err_r;
    end
  end

  assign out_err = out_err_r;
`endif

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_word   = out_word_r;
  assign out_parity = out_parity_r;

endmodule

// File: tb/tb_xor_parity_acc.sv
// Directed, table-driven bench for xor_parity_acc (FRAME_LEN=4 and FRAME_LEN=1 instances).
module tb_xor_parity_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_in_data = 8'h00;
  logic       a_out_valid;
  logic       a_out_ready = 1'b1;
  logic [7:0] a_out_word;
  logic       a_out_parity;
  logic       a_in_exp = 1'b0;
  logic       a_out_err;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in_data = 8'h00;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [7:0] b_out_word;
  logic       b_out_parity;
  logic       b_in_exp = 1'b0;
  logic       b_out_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] w2;
    logic [7:0] w3;
    int         gap;
    logic       exp_in;
    logic [7:0] exp_word;
    logic       exp_par;
  } frame_vec_t;

  frame_vec_t vecs [8];

  always #5 clk = ~clk;

  xor_parity_acc #(.DATA_W(8), .FRAME_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_data    (a_in_data),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_word   (a_out_word),
    .out_parity (a_out_parity)
`ifdef XOR_PARITY_ERRCHK_EN
    ,
    .in_exp     (a_in_exp),
    .out_err    (a_out_err)
`endif
  );

  xor_parity_acc #(.DATA_W(8), .FRAME_LEN(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_word   (b_out_word),
    .out_parity (b_out_parity)
`ifdef XOR_PARITY_ERRCHK_EN
    ,
    .in_exp     (b_in_exp),
    .out_err    (b_out_err)
`endif
  );

`ifndef XOR_PARITY_ERRCHK_EN
  assign a_out_err = 1'b0;
  assign b_out_err = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; each word transfers on the following posedge.
  task automatic send_words(input logic [31:0] words, input int n, input int gap, input logic exp_in);
    for (int i = 0; i < n; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = words[8*i +: 8];
      a_in_exp   = exp_in;
      check("in_ready_accum", {31'd0, a_in_ready}, 32'd1);
      check("out_valid_accum", {31'd0, a_out_valid}, 32'd0);
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_data  = 8'h00;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          check("in_ready_gap", {31'd0, a_in_ready}, 32'd1);
          check("out_valid_gap", {31'd0, a_out_valid}, 32'd0);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_result(input logic [7:0] exp_word, input logic exp_par, input logic exp_err);
    check("out_valid_done", {31'd0, a_out_valid}, 32'd1);
    check("out_word", {24'd0, a_out_word}, {24'd0, exp_word});
    check("out_parity", {31'd0, a_out_parity}, {31'd0, exp_par});
    check("in_ready_done", {31'd0, a_in_ready}, 32'd0);
`ifdef XOR_PARITY_ERRCHK_EN
    check("out_err", {31'd0, a_out_err}, {31'd0, exp_err});
`else
    if (exp_err !== 1'b0 && exp_err !== 1'b1) $display("exp_err unknown");
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {31'd0, a_out_valid}, 32'd0);
    check({tag, "_out_word"}, {24'd0, a_out_word}, 32'd0);
    check({tag, "_out_parity"}, {31'd0, a_out_parity}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, a_in_ready}, 32'd1);
`ifdef XOR_PARITY_ERRCHK_EN
    check({tag, "_out_err"}, {31'd0, a_out_err}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("watchdog expired at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    vecs[0] = '{8'h01, 8'h02, 8'h04, 8'h08, 0, 1'b0, 8'h0F, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'h01, 3, 1'b1, 8'hFE, 1'b1};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 0, 1'b1, 8'h08, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 8'hF0, 8'h00, 1, 1'b0, 8'h0F, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 2, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h07, 8'h00, 8'h00, 8'h00, 0, 1'b1, 8'h07, 1'b1};
    vecs[6] = '{8'h01, 8'h00, 8'h00, 8'h00, 0, 1'b0, 8'h01, 1'b1};
    vecs[7] = '{8'h01, 8'h00, 8'h00, 8'h00, 0, 1'b1, 8'h01, 1'b1};

    // Reset state while rst is held.
    @(negedge clk);
    check_idle("reset");
    check("reset_b_in_ready", {31'd0, b_in_ready}, 32'd1);
    check("reset_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      send_words({vecs[v].w3, vecs[v].w2, vecs[v].w1, vecs[v].w0}, 4, vecs[v].gap, vecs[v].exp_in);
      check_result(vecs[v].exp_word, vecs[v].exp_par, vecs[v].exp_par ^ vecs[v].exp_in);
      @(negedge clk);
      check_idle("drain");
    end

    // Downstream stall: result held, extra words refused, including the handoff cycle.
    a_out_ready = 1'b0;
    send_words(32'h88442211, 4, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'hFF;
      check_result(8'hFF, 1'b0, 1'b0);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    check("handoff_in_ready", {31'd0, a_in_ready}, 32'd0);
    @(negedge clk);
    a_in_valid = 1'b0;
    check_idle("after_stall");
    send_words(32'h00000001, 4, 0, 1'b1);
    check_result(8'h01, 1'b1, 1'b0);
    @(negedge clk);

    // Reset mid-frame discards the partial accumulation and count.
    send_words(32'h00000FF0, 2, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_words(32'h000055AA, 4, 0, 1'b0);
    check_result(8'hFF, 1'b0, 1'b0);
    @(negedge clk);

    // FRAME_LEN=1: direct IDLE->DONE and a bubble before the next word.
    b_in_valid = 1'b1;
    b_in_data  = 8'h03;
    check("len1_in_ready", {31'd0, b_in_ready}, 32'd1);
    @(negedge clk);
    check("len1_out_valid", {31'd0, b_out_valid}, 32'd1);
    check("len1_out_word", {24'd0, b_out_word}, 32'h03);
    check("len1_out_parity", {31'd0, b_out_parity}, 32'd0);
    check("len1_in_ready_done", {31'd0, b_in_ready}, 32'd0);
    b_in_data = 8'h05;
    @(negedge clk);
    check("len1_bubble_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("len1_bubble_in_ready", {31'd0, b_in_ready}, 32'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    check("len1_second_out_valid", {31'd0, b_out_valid}, 32'd1);
    check("len1_second_out_word", {24'd0, b_out_word}, 32'h05);
    check("len1_second_out_parity", {31'd0, b_out_parity}, 32'd0);
    @(negedge clk);
    check("len1_final_out_valid", {31'd0, b_out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_parity_acc.md
XOR_PARITY_ACC -- requirements
Module: xor_parity_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each input word (1..32).
REQ-002 SHALL have parameter FRAME_LEN, default 4, number of words per frame (1..256).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream word valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, word to fold into the frame.
REQ-008 SHALL have port out_valid, output, 1, frame result available.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes the result.
REQ-010 SHALL have port out_word, output, DATA_W, bitwise XOR of all words in the frame.
REQ-011 SHALL have port out_parity, output, 1, XOR-reduction of out_word (even parity bit).

Function
REQ-012 SHALL implement states IDLE (no word taken), ACCUM (1..FRAME_LEN-1 words taken), DONE (result held).
REQ-013 SHALL transfer an input word only when in_valid and in_ready are both 1 at a rising clk edge.
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in DONE.
REQ-015 SHALL, on each transfer, set acc <= acc ^ in_data and increment the word counter (width clog2(FRAME_LEN+1)).
REQ-016 SHALL go IDLE->ACCUM on the first transfer when FRAME_LEN>1.
REQ-017 SHALL go to DONE on the transfer that makes the count equal FRAME_LEN; with FRAME_LEN=1 this is IDLE->DONE directly.
REQ-018 SHALL assert out_valid exactly in DONE, starting the cycle after the last word transfer (latency 1).
REQ-019 SHALL hold out_word and out_parity stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on out_valid and out_ready both 1, return to IDLE next cycle with acc and counter cleared.
REQ-021 SHALL hold acc, counter and state when in_valid=0 mid-frame (gaps of any length allowed).
REQ-022 SHALL not accept a word in the DONE->IDLE handoff cycle (one-cycle bubble between frames).
REQ-023 SHALL drive out_word=0 and out_parity=0 whenever out_valid=0.

Reset
REQ-024 SHALL, on rst=1, asynchronously force state IDLE, acc=0, counter=0, in_ready=1, out_valid=0, out_word=0, out_parity=0.
REQ-025 SHALL discard any partial frame or held result when rst asserts mid-operation; the first frame after reset starts clean.

Configuration
REQ-026 SHALL support macro XOR_PARITY_ERRCHK_EN.
REQ-027 With XOR_PARITY_ERRCHK_EN defined, SHALL add input in_exp (1, expected parity, sampled with the last word) and output out_err (1, out_parity != captured in_exp, valid with out_valid, 0 otherwise and at reset).
REQ-028 Without XOR_PARITY_ERRCHK_EN, SHALL have neither port and no capture register.

Structure
REQ-029 SHALL place the state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the counter-width function in package xor_parity_pkg.
REQ-030 SHALL instantiate one sub-module xor_reduce (parameter W, input vector, 1-bit XOR output) for out_parity.

Verification
REQ-031 SHALL cover: DATA_W=8, FRAME_LEN=4, words 0x01,0x02,0x04,0x08 back-to-back, out_ready=1 -> out_valid one cycle after the 4th word, out_word=0x0F, out_parity=0.
REQ-032 SHALL cover: words 0xFF,0x00,0x00,0x01 with in_valid low 3 cycles between words -> out_word=0xFE, out_parity=1, in_ready high throughout accumulation.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles after result -> out_valid, out_word stable; in_ready=0; extra in_valid words are not taken.
REQ-034 SHALL cover: rst pulse after 2 of 4 words, then 0xAA,0x55,0x00,0x00 -> out_word=0xFF (no residue from the aborted frame).
REQ-035 SHALL cover: FRAME_LEN=1, word 0x03 -> IDLE->DONE, out_word=0x03, out_parity=0; bubble cycle before the next word is accepted.
REQ-036 SHALL cover, with XOR_PARITY_ERRCHK_EN: frame 0x01,0x00,0x00,0x00 with in_exp=0 -> out_err=1; same frame with in_exp=1 -> out_err=0.
